// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter and its helpers.
package uart_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  // Successor of a requester index, wrapping at n.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx,
                                                input int unsigned      n);
    return ((32'(idx) + 32'd1) >= n) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester/uart_tx bundle around the arbiter. With UART_TX_ARBITER_TIMEOUT_EN
// defined the bundle also carries the owner-stall timeout_pulse.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]             req;
  logic [UART_BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ-1:0]             ack;
  logic [IDX_W-1:0]               owner;
  logic                           busy;
  logic [UART_BYTE_W-1:0]         tx_data;
  logic                           tx_en;
  logic                           tx_busy;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic                           timeout_pulse;

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, owner, busy, tx_data, tx_en, timeout_pulse
  );

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, owner, busy, tx_data, tx_en, timeout_pulse
  );
`else
  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, owner, busy, tx_data, tx_en
  );

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, owner, busy, tx_data, tx_en
  );
`endif

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [MAX_REQ-1:0] req_ext;

  assign req_ext = MAX_REQ'(req_i);

  // Walk from the farthest candidate back so the closest hit to ptr_i wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_ext[IDX_W'((32'(ptr_i) + 32'(i)) % NUM_REQ)]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'((32'(ptr_i) + 32'(i)) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one uart_tx among NUM_REQ
// byte-stream requesters. UART_TX_ARBITER_TIMEOUT_EN adds an owner-stall timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   busy_q, busy_d;
  logic                   last_q, last_d;
  logic                   tx_en_q, tx_en_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;

  // Requester vectors padded to the full index range so owner_q indexes cleanly.
  logic [MAX_REQ-1:0]             req_ext;
  logic [MAX_REQ-1:0]             last_ext;
  logic [UART_BYTE_W*MAX_REQ-1:0] data_ext;
  logic                           pick_hit;
  logic [IDX_W-1:0]               pick_idx;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  localparam int STALL_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [STALL_W-1:0] stall_q, stall_d;
  logic               timeout_q, timeout_d;
`endif

  assign req_ext  = MAX_REQ'(bus.req);
  assign last_ext = MAX_REQ'(bus.req_last);
  assign data_ext = (UART_BYTE_W*MAX_REQ)'(bus.req_data);

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    busy_d    = busy_q;
    last_d    = last_q;
    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    ack_d     = '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    stall_d   = stall_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          owner_d = pick_idx;
          busy_d  = 1'b1;
          state_d = ISSUE;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
          stall_d = '0;
`endif
        end
      end

      ISSUE: begin
        if (req_ext[owner_q] && !bus.tx_busy) begin
          tx_data_d = data_ext[{owner_q, 3'b000} +: UART_BYTE_W];
          tx_en_d   = 1'b1;
          ack_d     = NUM_REQ'(1 << owner_q);
          last_d    = last_ext[owner_q];
          state_d   = HOLD;
        end
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        // An owner that stops offering bytes is evicted without a tx_en.
        else if (!req_ext[owner_q]) begin
          if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
`endif
      end

      // uart_tx needs this cycle to raise tx_busy, so it is not consulted here.
      HOLD: begin
        state_d = last_q ? DRAIN : ISSUE;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        stall_d = '0;
`endif
      end

      DRAIN: begin
        if (!bus.tx_busy) begin
          busy_d   = 1'b0;
          rr_ptr_d = wrap_inc(owner_q, NUM_REQ);
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      tx_data_q <= '0;
      tx_en_q   <= 1'b0;
      ack_q     <= '0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      stall_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      busy_q    <= busy_d;
      last_q    <= last_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      ack_q     <= ack_d;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.ack     = ack_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = busy_q;
  assign bus.tx_data = tx_data_q;
  assign bus.tx_en   = tx_en_q;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
  assign bus.timeout_pulse = timeout_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, a uart_tx busy
// model and a message-level round-robin reference model feeding a scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus();

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  drv_q [NR][$];   // {last, byte} the requester still has to hand over
  logic [8:0]  mdl_q [NR][$];   // same messages as seen by the reference model
  logic [10:0] exp_q [$];       // {owner, byte} in expected transmit order
  int          m_ptr = 0;       // model's round-robin start
  int          n_txen = 0;
  int          ack_cnt [NR];
  bit          rand_busy = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic add_byte(input int i, input logic [7:0] b, input logic last, input bit to_model);
    drv_q[i].push_back({last, b});
    if (to_model) mdl_q[i].push_back({last, b});
  endtask

  // Reference: whole messages, granted round-robin starting at m_ptr.
  task automatic run_model();
    bit any;
    logic [8:0] e;
    int w;
    any = 1'b1;
    while (any) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        if (w < 0 && mdl_q[(m_ptr + k) % NR].size() > 0) w = (m_ptr + k) % NR;
      end
      if (w < 0) begin
        any = 1'b0;
      end else begin
        bit fin;
        fin = 1'b0;
        while (!fin && mdl_q[w].size() > 0) begin
          e = mdl_q[w].pop_front();
          exp_q.push_back({3'(w), e[7:0]});
          fin = e[8];
        end
        m_ptr = (w + 1) % NR;
      end
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      @(negedge clk);
      n++;
      done = (exp_q.size() == 0) && !bus.busy;
      for (int i = 0; i < NR; i++) if (drv_q[i].size() != 0) done = 1'b0;
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_ack(input int i, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.ack[i];
    end
    check_val($sformatf("ack%0d_seen", i), 32'(seen), 32'd1);
  endtask

  // Requesters: present the head byte; retire it on the cycle ack is seen.
  initial begin
    logic [8:0] h;
    forever begin
      for (int i = 0; i < NR; i++) begin
        if (bus.ack[i] === 1'b1 && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
        if (drv_q[i].size() > 0) begin
          h = drv_q[i][0];
          bus.req[i]              = 1'b1;
          bus.req_data[8*i +: 8]  = h[7:0];
          bus.req_last[i]         = h[8];
        end else begin
          bus.req[i]              = 1'b0;
          bus.req_data[8*i +: 8]  = 8'h00;
          bus.req_last[i]         = 1'b0;
        end
      end
      @(negedge clk);
    end
  end

  // uart_tx stand-in: tx_busy rises the cycle after tx_en and stays for a while.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tx_en === 1'b1) begin
        bus.tx_busy = 1'b1;
        repeat (rand_busy ? $urandom_range(1, 12) : 10) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  // Scoreboard on every transmitted byte.
  initial begin
    logic [10:0] e;
    bit prev_txen, prev_busy;
    prev_txen = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) if (bus.ack[i] === 1'b1) ack_cnt[i]++;
      if (bus.tx_en === 1'b1) begin
        n_txen++;
        check_val("tx_en_single_cycle", 32'(prev_txen), 32'd0);
        check_val("tx_en_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_val("tx_data", 32'(bus.tx_data), 32'(e[7:0]));
          check_val("owner", 32'(bus.owner), 32'(e[10:8]));
          check_val("ack_onehot", 32'(bus.ack), 32'(1) << e[10:8]);
        end
      end else begin
        check_val("ack_idle", 32'(bus.ack), 32'd0);
      end
      if (rst_n && prev_busy && !bus.busy)
        check_val("busy_fall_tx_busy", 32'(bus.tx_busy), 32'd0);
      prev_txen = (bus.tx_en === 1'b1);
      prev_busy = (bus.busy === 1'b1);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, txen0, ack0, ack2;
    bit seen;
    int nm, len;

    // Reset with every requester asserting.
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) add_byte(i, 8'h10 + 8'(i), 1'b1, 1'b1);
    run_model();
    repeat (3) begin
      @(negedge clk);
      check_val("rst_ack", 32'(bus.ack), 32'd0);
      check_val("rst_tx_en", 32'(bus.tx_en), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_owner", 32'(bus.owner), 32'd0);
      check_val("rst_tx_data", 32'(bus.tx_data), 32'd0);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      check_val("rst_timeout", 32'(bus.timeout_pulse), 32'd0);
`endif
    end
    rst_n = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 20 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.busy;
    end
    check_val("first_grant_busy", 32'(seen), 32'd1);
    check_val("first_grant_owner", 32'(bus.owner), 32'd0);
    wait_idle("reset_drain", 500);

    // Round-robin with requester 2 silent: 0,1,3,0,1,3.
    ack2 = ack_cnt[2];
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      add_byte(0, 8'hA0, 1'b1, 1'b1);
      add_byte(1, 8'hA1, 1'b1, 1'b1);
      add_byte(3, 8'hA3, 1'b1, 1'b1);
    end
    run_model();
    wait_idle("rr_drain", 1000);
    check_val("rr_req2_never_acked", 32'(ack_cnt[2] - ack2), 32'd0);

    // Single requester, 3-byte message.
    txen0 = n_txen;
    ack0  = ack_cnt[0];
    @(posedge clk); #1;
    add_byte(0, 8'h48, 1'b0, 1'b1);
    add_byte(0, 8'h65, 1'b0, 1'b1);
    add_byte(0, 8'h0A, 1'b1, 1'b1);
    run_model();
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.tx_en;
    end
    // Byte presented on the first negedge, so tx_en two cycles after sampling.
    check_val("first_byte_latency", 32'(n), 32'd3);
    wait_idle("msg3_drain", 500);
    check_val("msg3_tx_en_count", 32'(n_txen - txen0), 32'd3);
    check_val("msg3_ack_count", 32'(ack_cnt[0] - ack0), 32'd3);

    // Lock: requester 0 arrives while requester 1 is mid-message.
    @(posedge clk); #1;
    add_byte(1, 8'h31, 1'b0, 1'b1);
    add_byte(1, 8'h32, 1'b0, 1'b1);
    add_byte(1, 8'h33, 1'b0, 1'b1);
    add_byte(1, 8'h34, 1'b1, 1'b1);
    run_model();
    wait_ack(1, 200);
    wait_ack(1, 200);
    @(posedge clk); #1;
    add_byte(0, 8'h35, 1'b1, 1'b1);
    run_model();
    wait_idle("lock_drain", 1000);

    // Owner stalls after its first byte; requester 2 is waiting.
    txen0 = n_txen;
    ack2  = ack_cnt[2];
    @(posedge clk); #1;
    add_byte(1, 8'h51, 1'b0, 1'b0);
    exp_q.push_back({3'd1, 8'h51});
    add_byte(2, 8'h52, 1'b0, 1'b1);
    add_byte(2, 8'h53, 1'b1, 1'b1);
    wait_ack(1, 200);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    n = 0;
    seen = 1'b0;
    while (n < 100 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.timeout_pulse;
    end
    // One HOLD cycle, then TO stalled cycles in ISSUE.
    check_val("timeout_delay", 32'(n), 32'(TO + 1));
    @(negedge clk);
    check_val("timeout_single_cycle", 32'(bus.timeout_pulse), 32'd0);
    check_val("timeout_no_tx_en", 32'(n_txen - txen0), 32'd1);
    m_ptr = 2;
    run_model();
    wait_idle("timeout_drain", 1000);
`else
    repeat (1000) @(negedge clk);
    check_val("lock_owner", 32'(bus.owner), 32'd1);
    check_val("lock_busy", 32'(bus.busy), 32'd1);
    check_val("lock_no_tx_en", 32'(n_txen - txen0), 32'd1);
    check_val("lock_req2_waiting", 32'(ack_cnt[2] - ack2), 32'd0);
    @(posedge clk); #1;
    add_byte(1, 8'h5F, 1'b1, 1'b0);
    exp_q.push_back({3'd1, 8'h5F});
    m_ptr = 2;
    run_model();
    wait_idle("lock_release_drain", 1000);
`endif

    // Reset one cycle after a tx_en in the middle of a message.
    @(posedge clk); #1;
    add_byte(3, 8'h61, 1'b0, 1'b0);
    add_byte(3, 8'h62, 1'b0, 1'b0);
    add_byte(3, 8'h63, 1'b1, 1'b0);
    exp_q.push_back({3'd3, 8'h61});
    n = 0;
    seen = 1'b0;
    while (n < 60 && !seen) begin
      @(negedge clk);
      n++;
      seen = bus.tx_en;
    end
    check_val("midreset_tx_en_seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      drv_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    m_ptr = 0;
    @(negedge clk);
    check_val("midreset_busy", 32'(bus.busy), 32'd0);
    check_val("midreset_ack", 32'(bus.ack), 32'd0);
    check_val("midreset_tx_en", 32'(bus.tx_en), 32'd0);
    check_val("midreset_owner", 32'(bus.owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    add_byte(3, 8'h71, 1'b1, 1'b1);
    add_byte(0, 8'h70, 1'b0, 1'b1);
    add_byte(0, 8'h7F, 1'b1, 1'b1);
    run_model();
    wait_idle("post_reset_drain", 1000);

    // Randomised rounds of mixed-length messages and uart busy times.
    rand_busy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        nm = $urandom_range(0, 2);
        for (int m = 0; m < nm; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) add_byte(i, 8'($urandom), b == len - 1, 1'b1);
        end
      end
      run_model();
      wait_idle($sformatf("random_round%0d_drain", r), 3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
